// File: rtl/asyn_fifo_flags.sv
// rtl/asyn_fifo_flags.sv - dual-clock Gray-pointer FIFO with threshold flags, fill counts and sticky errors
module asyn_fifo_flags #(
  parameter int DSIZE         = 8,
  parameter int ASIZE         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic             W_CLK,
  input  logic             W_RESET,
  input  logic             R_CLK,
  input  logic             R_RESET,
  input  logic [DSIZE-1:0] W_DATA,
  input  logic             WRITE,
  output logic             FULL,
  output logic             ALMOST_FULL,
  output logic [ASIZE:0]   W_COUNT,
  output logic             W_OVERFLOW,
  input  logic             READ,
  output logic [DSIZE-1:0] R_DATA,
  output logic             R_VALID,
  output logic             EMPTY,
  output logic             ALMOST_EMPTY,
  output logic [ASIZE:0]   R_COUNT,
  output logic             R_UNDERFLOW
);

  localparam int PW    = ASIZE + 1;
  localparam int DEPTH = 1 << ASIZE;
  // Gray codes DEPTH apart differ only in their top two bits.
  localparam logic [ASIZE:0] FULL_MASK = PW'(3) << (ASIZE - 1);
  localparam logic [ASIZE:0] AFULL_T   = PW'(AFULL_THRESH);
  localparam logic [ASIZE:0] AEMPTY_T  = PW'(AEMPTY_THRESH);

  function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0] wbin_q, wbin_d, wgray_q, wgray_d;
  logic [ASIZE:0] rbin_q, rbin_d, rgray_q, rgray_d;
  logic [ASIZE:0] rq_sync_q [SYNC_STAGES];
  logic [ASIZE:0] wq_sync_q [SYNC_STAGES];

  logic           full_q, full_d, afull_q, afull_d, ovf_q, ovf_d;
  logic [ASIZE:0] wcount_q, wcount_d;
  logic           empty_q, empty_d, aempty_q, aempty_d, unf_q, unf_d, rvalid_q;
  logic [ASIZE:0] rcount_q, rcount_d;
  logic [DSIZE-1:0] rdata_q;
  logic           w_en, r_en;

  // Write domain
  always_comb begin
    w_en     = WRITE && !full_q;
    wbin_d   = wbin_q + PW'(w_en);
    wgray_d  = bin2gray(wbin_d);
    full_d   = (wgray_d ^ rq_sync_q[SYNC_STAGES-1]) == FULL_MASK;
    wcount_d = wbin_d - gray2bin(rq_sync_q[SYNC_STAGES-1]);
    afull_d  = wcount_d >= AFULL_T;
    ovf_d    = ovf_q || (WRITE && full_q);
  end

  always_ff @(posedge W_CLK) begin
    if (w_en) mem[wbin_q[ASIZE-1:0]] <= W_DATA;
  end

  always_ff @(posedge W_CLK) begin
    if (W_RESET) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      wcount_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) rq_sync_q[i] <= '0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      wcount_q <= wcount_d;
      ovf_q    <= ovf_d;
      rq_sync_q[0] <= rgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) rq_sync_q[i] <= rq_sync_q[i-1];
    end
  end

  // Read domain
  always_comb begin
    r_en     = READ && !empty_q;
    rbin_d   = rbin_q + PW'(r_en);
    rgray_d  = bin2gray(rbin_d);
    empty_d  = rgray_d == wq_sync_q[SYNC_STAGES-1];
    rcount_d = gray2bin(wq_sync_q[SYNC_STAGES-1]) - rbin_d;
    aempty_d = rcount_d <= AEMPTY_T;
    unf_d    = unf_q || (READ && empty_q);
  end

  always_ff @(posedge R_CLK) begin
    if (R_RESET) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      rcount_q <= '0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) wq_sync_q[i] <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      rcount_q <= rcount_d;
      unf_q    <= unf_d;
      rvalid_q <= r_en;
      if (r_en) rdata_q <= mem[rbin_q[ASIZE-1:0]];
      wq_sync_q[0] <= wgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) wq_sync_q[i] <= wq_sync_q[i-1];
    end
  end

  assign FULL         = full_q;
  assign ALMOST_FULL  = afull_q;
  assign W_COUNT      = wcount_q;
  assign W_OVERFLOW   = ovf_q;
  assign R_DATA       = rdata_q;
  assign R_VALID      = rvalid_q;
  assign EMPTY        = empty_q;
  assign ALMOST_EMPTY = aempty_q;
  assign R_COUNT      = rcount_q;
  assign R_UNDERFLOW  = unf_q;

endmodule

// File: tb/tb_asyn_fifo_flags.sv
// tb/tb_asyn_fifo_flags.sv - directed bench for asyn_fifo_flags
module tb_asyn_fifo_flags;

  logic       W_CLK = 1'b0;
  logic       R_CLK = 1'b0;
  logic       W_RESET = 1'b1;
  logic       R_RESET = 1'b1;
  logic [7:0] W_DATA = '0;
  logic       WRITE = 1'b0;
  logic       READ = 1'b0;
  logic       FULL, ALMOST_FULL, W_OVERFLOW;
  logic       R_VALID, EMPTY, ALMOST_EMPTY, R_UNDERFLOW;
  logic [4:0] W_COUNT, R_COUNT;
  logic [7:0] R_DATA;

  int checks = 0;
  int errors = 0;

  always #10 W_CLK = ~W_CLK;
  always #12 R_CLK = ~R_CLK;

  asyn_fifo_flags #(
    .DSIZE(8), .ASIZE(4), .SYNC_STAGES(2), .AFULL_THRESH(12), .AEMPTY_THRESH(4)
  ) dut (
    .W_CLK(W_CLK), .W_RESET(W_RESET), .R_CLK(R_CLK), .R_RESET(R_RESET),
    .W_DATA(W_DATA), .WRITE(WRITE), .FULL(FULL), .ALMOST_FULL(ALMOST_FULL),
    .W_COUNT(W_COUNT), .W_OVERFLOW(W_OVERFLOW),
    .READ(READ), .R_DATA(R_DATA), .R_VALID(R_VALID), .EMPTY(EMPTY),
    .ALMOST_EMPTY(ALMOST_EMPTY), .R_COUNT(R_COUNT), .R_UNDERFLOW(R_UNDERFLOW)
  );

  task automatic do_reset(input int r_cycles);
    W_RESET = 1'b1;
    R_RESET = 1'b1;
    WRITE = 1'b0;
    READ = 1'b0;
    repeat (r_cycles) @(posedge R_CLK);
    #1;
    W_RESET = 1'b0;
    R_RESET = 1'b0;
    @(posedge W_CLK); #1;
  endtask

  task automatic test_reset();
    do_reset(8);
    checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", FULL); end
    checks++; if (ALMOST_FULL !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", ALMOST_FULL); end
    checks++; if (W_COUNT !== 5'd0) begin errors++; $display("FAIL reset_wcount got %0d exp 0", W_COUNT); end
    checks++; if (W_OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", W_OVERFLOW); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", EMPTY); end
    checks++; if (ALMOST_EMPTY !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b exp 1", ALMOST_EMPTY); end
    checks++; if (R_COUNT !== 5'd0) begin errors++; $display("FAIL reset_rcount got %0d exp 0", R_COUNT); end
    checks++; if (R_VALID !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", R_VALID); end
    checks++; if (R_DATA !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", R_DATA); end
    checks++; if (R_UNDERFLOW !== 1'b0) begin errors++; $display("FAIL reset_unf got %b exp 0", R_UNDERFLOW); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      W_DATA = 8'(i * 2);
      WRITE = 1'b1;
      @(posedge W_CLK); #1;
      checks++; if (W_COUNT !== 5'(i + 1)) begin errors++; $display("FAIL fill_wcount[%0d] got %0d exp %0d", i, W_COUNT, i + 1); end
      checks++; if (FULL !== (i == 15)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, FULL, i == 15); end
      checks++; if (ALMOST_FULL !== (i >= 11)) begin errors++; $display("FAIL fill_afull[%0d] got %b exp %b", i, ALMOST_FULL, i >= 11); end
    end
    WRITE = 1'b0;
  endtask

  task automatic test_overflow();
    W_DATA = 8'hAA;
    WRITE = 1'b1;
    @(posedge W_CLK); #1;
    WRITE = 1'b0;
    checks++; if (W_OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", W_OVERFLOW); end
    checks++; if (W_COUNT !== 5'd16) begin errors++; $display("FAIL ovf_wcount got %0d exp 16", W_COUNT); end
    checks++; if (FULL !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", FULL); end
  endtask

  task automatic test_drain();
    repeat (6) @(posedge R_CLK);
    #1;
    checks++; if (R_COUNT !== 5'd16) begin errors++; $display("FAIL drain_rcount0 got %0d exp 16", R_COUNT); end
    checks++; if (EMPTY !== 1'b0) begin errors++; $display("FAIL drain_empty0 got %b exp 0", EMPTY); end
    checks++; if (ALMOST_EMPTY !== 1'b0) begin errors++; $display("FAIL drain_aempty0 got %b exp 0", ALMOST_EMPTY); end
    READ = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge R_CLK); #1;
      if (i == 15) READ = 1'b0;
      checks++; if (R_VALID !== 1'b1) begin errors++; $display("FAIL drain_rvalid[%0d] got %b exp 1", i, R_VALID); end
      checks++; if (R_DATA !== 8'(i * 2)) begin errors++; $display("FAIL drain_rdata[%0d] got %h exp %h", i, R_DATA, 8'(i * 2)); end
      checks++; if (R_COUNT !== 5'(15 - i)) begin errors++; $display("FAIL drain_rcount[%0d] got %0d exp %0d", i, R_COUNT, 15 - i); end
      checks++; if (EMPTY !== (i == 15)) begin errors++; $display("FAIL drain_empty[%0d] got %b exp %b", i, EMPTY, i == 15); end
      checks++; if (ALMOST_EMPTY !== (i >= 11)) begin errors++; $display("FAIL drain_aempty[%0d] got %b exp %b", i, ALMOST_EMPTY, i >= 11); end
    end
    @(posedge R_CLK); #1;
    checks++; if (R_VALID !== 1'b0) begin errors++; $display("FAIL drain_rvalid_end got %b exp 0", R_VALID); end
    repeat (6) @(posedge W_CLK);
    #1;
    checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL drain_full_end got %b exp 0", FULL); end
    checks++; if (W_COUNT !== 5'd0) begin errors++; $display("FAIL drain_wcount_end got %0d exp 0", W_COUNT); end
    checks++; if (W_OVERFLOW !== 1'b1) begin errors++; $display("FAIL drain_ovf_sticky got %b exp 1", W_OVERFLOW); end
  endtask

  task automatic test_underflow();
    @(posedge R_CLK); #1;
    READ = 1'b1;
    @(posedge R_CLK); #1;
    READ = 1'b0;
    checks++; if (R_UNDERFLOW !== 1'b1) begin errors++; $display("FAIL unf_flag got %b exp 1", R_UNDERFLOW); end
    checks++; if (R_VALID !== 1'b0) begin errors++; $display("FAIL unf_rvalid got %b exp 0", R_VALID); end
    checks++; if (R_DATA !== 8'h1E) begin errors++; $display("FAIL unf_rdata_hold got %h exp 1e", R_DATA); end
    do_reset(4);
    checks++; if (R_UNDERFLOW !== 1'b0) begin errors++; $display("FAIL unf_clear got %b exp 0", R_UNDERFLOW); end
    checks++; if (W_OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", W_OVERFLOW); end
  endtask

  task automatic test_stream();
    int w_idx = 0;
    int r_idx = 0;
    fork
      begin
        int budget = 3000;
        while (w_idx < 64 && budget > 0) begin
          logic do_w;
          do_w = ($urandom_range(0, 3) != 0) && !FULL;
          WRITE = do_w;
          W_DATA = 8'(w_idx * 2);
          @(posedge W_CLK); #1;
          if (do_w) w_idx++;
          budget--;
        end
        WRITE = 1'b0;
      end
      begin
        int budget = 3000;
        while (r_idx < 64 && budget > 0) begin
          READ = ($urandom_range(0, 2) != 0) && !EMPTY;
          @(posedge R_CLK); #1;
          READ = 1'b0;
          checks++; if (FULL && EMPTY) begin errors++; $display("FAIL stream_full_and_empty got 1 exp 0"); end
          if (R_VALID) begin
            checks++; if (R_DATA !== 8'(r_idx * 2)) begin errors++; $display("FAIL stream_rdata[%0d] got %h exp %h", r_idx, R_DATA, 8'(r_idx * 2)); end
            r_idx++;
          end
          budget--;
        end
        READ = 1'b0;
      end
    join
    checks++; if (r_idx !== 64) begin errors++; $display("FAIL stream_count got %0d exp 64", r_idx); end
    repeat (6) @(posedge R_CLK);
    #1;
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL stream_empty_end got %b exp 1", EMPTY); end
    checks++; if (R_COUNT !== 5'd0) begin errors++; $display("FAIL stream_rcount_end got %0d exp 0", R_COUNT); end
    checks++; if (R_UNDERFLOW !== 1'b0) begin errors++; $display("FAIL stream_unf got %b exp 0", R_UNDERFLOW); end
    checks++; if (W_OVERFLOW !== 1'b0) begin errors++; $display("FAIL stream_ovf got %b exp 0", W_OVERFLOW); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) begin
      W_DATA = 8'(8'h10 + i);
      WRITE = 1'b1;
      @(posedge W_CLK); #1;
    end
    WRITE = 1'b0;
    checks++; if (W_COUNT !== 5'd9) begin errors++; $display("FAIL mid_wcount_pre got %0d exp 9", W_COUNT); end
    repeat (5) @(posedge R_CLK);
    do_reset(4);
    repeat (4) @(posedge R_CLK);
    #1;
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL mid_empty got %b exp 1", EMPTY); end
    checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL mid_full got %b exp 0", FULL); end
    checks++; if (W_COUNT !== 5'd0) begin errors++; $display("FAIL mid_wcount got %0d exp 0", W_COUNT); end
    checks++; if (R_COUNT !== 5'd0) begin errors++; $display("FAIL mid_rcount got %0d exp 0", R_COUNT); end
    @(posedge W_CLK); #1;
    W_DATA = 8'h55;
    WRITE = 1'b1;
    @(posedge W_CLK); #1;
    WRITE = 1'b0;
    repeat (6) @(posedge R_CLK);
    #1;
    checks++; if (R_COUNT !== 5'd1) begin errors++; $display("FAIL mid_rcount_one got %0d exp 1", R_COUNT); end
    READ = 1'b1;
    @(posedge R_CLK); #1;
    READ = 1'b0;
    checks++; if (R_VALID !== 1'b1) begin errors++; $display("FAIL mid_rvalid got %b exp 1", R_VALID); end
    checks++; if (R_DATA !== 8'h55) begin errors++; $display("FAIL mid_rdata got %h exp 55", R_DATA); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL mid_empty_after got %b exp 1", EMPTY); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_stream();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
